// File: rtl/fetch_pc_gen.sv
// Fetch-stage-0 PC generator: one fetch-group address per accepted cycle, with slot mask,
// redirect epoch, prioritised backend redirects, predictor redirect and boot/halt control.
module fetch_pc_gen #(
   parameter int XLEN        = 64,
   parameter int FETCH_WIDTH = 4,
   parameter int NUM_REDIR   = 2,
   parameter int EPOCH_W     = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [XLEN-1:0]           reset_vec,
   input  logic [NUM_REDIR-1:0]      redir_valid_i,
   input  logic [NUM_REDIR*XLEN-1:0] redir_pc_i,
   input  logic                      pred_valid_i,
   input  logic [XLEN-1:0]           pred_pc_i,
   input  logic                      halt_i,
   input  logic                      f0_ready_i,
   output logic                      f0_valid_o,
   output logic [XLEN-1:0]           f0_pc_o,
   output logic [FETCH_WIDTH-1:0]    f0_mask_o,
   output logic [EPOCH_W-1:0]        f0_epoch_o,
   output logic [1:0]                state_o
);

   localparam int FETCH_BYTES = 4 * FETCH_WIDTH;
   localparam int OFF         = $clog2(FETCH_BYTES);
   localparam logic [XLEN-1:0] WORD_MASK  = ~XLEN'(3);
   localparam logic [XLEN-1:0] GROUP_MASK = ~XLEN'(FETCH_BYTES - 1);
   localparam logic [XLEN-1:0] GROUP_STEP = XLEN'(FETCH_BYTES);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [XLEN-1:0]     r_pc;
   logic [EPOCH_W-1:0]  r_epoch;
   logic                w_redirAny;
   logic [XLEN-1:0]     w_redirPc;
   logic [XLEN-1:0]     w_curPc;
   logic [XLEN-1:0]     w_nextPc;
   logic                w_valid;
   logic                w_fire;

   // Walk from the highest index down so the lowest-index request overrides the rest.
   always_comb begin
      w_redirPc = '0;
      for (int i = NUM_REDIR - 1; i >= 0; i--) begin
         if (redir_valid_i[i]) begin
            w_redirPc = redir_pc_i[i*XLEN +: XLEN] & WORD_MASK;
         end
      end
   end

   assign w_redirAny = |redir_valid_i;
   assign w_curPc    = w_redirAny ? w_redirPc : r_pc;
   assign w_fire     = w_valid & f0_ready_i;

   always_comb begin
      w_valid     = 1'b0;
      w_nextState = r_state;
      case (r_state)
         BOOT: begin
            w_valid     = w_redirAny;
            w_nextState = RUN;
         end
         RUN: begin
            w_valid = !halt_i || w_redirAny;
            if (halt_i && !w_redirAny) begin
               w_nextState = HALT;
            end
         end
         HALT: begin
            w_valid = w_redirAny;
         end
         default: begin
            w_valid     = w_redirAny;
            w_nextState = RUN;
         end
      endcase
      if (w_redirAny) begin
         w_nextState = RUN;
      end
   end

   // A redirect that fires this cycle has already been issued, so advance past its group.
   always_comb begin
      w_nextPc = r_pc;
      if (w_redirAny) begin
         w_nextPc = w_fire ? (w_redirPc & GROUP_MASK) + GROUP_STEP : w_redirPc;
      end else if (w_fire && pred_valid_i) begin
         w_nextPc = pred_pc_i & WORD_MASK;
      end else if (w_fire) begin
         w_nextPc = (w_curPc & GROUP_MASK) + GROUP_STEP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BOOT;
         r_pc    <= reset_vec & WORD_MASK;
         r_epoch <= '0;
      end else begin
         r_state <= w_nextState;
         r_pc    <= w_nextPc;
         r_epoch <= f0_epoch_o;
      end
   end

   assign f0_valid_o = w_valid;
   assign f0_pc_o    = w_curPc;
   assign f0_epoch_o = w_redirAny ? r_epoch + EPOCH_W'(1) : r_epoch;
   assign state_o    = r_state;

   // Slots before the entry point of the group are masked off.
   if (FETCH_WIDTH == 1) begin : g_maskOne
      assign f0_mask_o = 1'b1;
   end else begin : g_maskMulti
      localparam int SW = OFF - 2;
      logic [SW-1:0] w_slot;
      assign w_slot = w_curPc[OFF-1:2];
      always_comb begin
         f0_mask_o = '0;
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            f0_mask_o[k] = (SW'(k) >= w_slot);
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: table of per-cycle vectors feeding a scoreboard queue,
// plus hand-written asynchronous reset sequences.
module tb_fetch_pc_gen;

   localparam int XLEN = 64;
   localparam int FW   = 4;
   localparam int NR   = 2;
   localparam int EW   = 3;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [XLEN-1:0]     reset_vec;
   logic [NR-1:0]       redir_valid_i;
   logic [NR*XLEN-1:0]  redir_pc_i;
   logic                pred_valid_i;
   logic [XLEN-1:0]     pred_pc_i;
   logic                halt_i;
   logic                f0_ready_i;
   logic                f0_valid_o;
   logic [XLEN-1:0]     f0_pc_o;
   logic [FW-1:0]       f0_mask_o;
   logic [EW-1:0]       f0_epoch_o;
   logic [1:0]          state_o;

   always #5 clk = ~clk;

   fetch_pc_gen #(.XLEN(XLEN), .FETCH_WIDTH(FW), .NUM_REDIR(NR), .EPOCH_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .reset_vec(reset_vec),
      .redir_valid_i(redir_valid_i), .redir_pc_i(redir_pc_i),
      .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
      .halt_i(halt_i), .f0_ready_i(f0_ready_i),
      .f0_valid_o(f0_valid_o), .f0_pc_o(f0_pc_o), .f0_mask_o(f0_mask_o),
      .f0_epoch_o(f0_epoch_o), .state_o(state_o)
   );

   typedef struct {
      logic [NR-1:0]   redirValid;
      logic [XLEN-1:0] pc0;
      logic [XLEN-1:0] pc1;
      logic            predValid;
      logic [XLEN-1:0] predPc;
      logic            halt;
      logic            ready;
      logic            expValid;
      logic [XLEN-1:0] expPc;
      logic [FW-1:0]   expMask;
      logic [EW-1:0]   expEpoch;
      logic [1:0]      expState;
   } vec_t;

   typedef struct {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [FW-1:0]   mask;
      logic [EW-1:0]   epoch;
      logic [1:0]      state;
   } exp_t;

   vec_t vecs[$];
   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   task automatic addVec(input logic [NR-1:0] rv, input logic [XLEN-1:0] pc0, input logic [XLEN-1:0] pc1,
                         input logic pv, input logic [XLEN-1:0] ppc, input logic halt, input logic ready,
                         input logic ev, input logic [XLEN-1:0] epc, input logic [FW-1:0] emask,
                         input logic [EW-1:0] eep, input logic [1:0] est);
      vec_t v;
      v.redirValid = rv;  v.pc0 = pc0;  v.pc1 = pc1;
      v.predValid = pv;   v.predPc = ppc;
      v.halt = halt;      v.ready = ready;
      v.expValid = ev;    v.expPc = epc;  v.expMask = emask;
      v.expEpoch = eep;   v.expState = est;
      vecs.push_back(v);
   endtask

   task automatic checkField(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      redir_valid_i = v.redirValid;
      redir_pc_i    = {v.pc1, v.pc0};
      pred_valid_i  = v.predValid;
      pred_pc_i     = v.predPc;
      halt_i        = v.halt;
      f0_ready_i    = v.ready;
      e.valid = v.expValid;  e.pc = v.expPc;  e.mask = v.expMask;
      e.epoch = v.expEpoch;  e.state = v.expState;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
      end else begin
         e = expQ.pop_front();
         checkField({tag, " valid"}, XLEN'(f0_valid_o), XLEN'(e.valid));
         checkField({tag, " pc"},    f0_pc_o,           e.pc);
         checkField({tag, " mask"},  XLEN'(f0_mask_o),  XLEN'(e.mask));
         checkField({tag, " epoch"}, XLEN'(f0_epoch_o), XLEN'(e.epoch));
         checkField({tag, " state"}, XLEN'(state_o),    XLEN'(e.state));
      end
   endtask

   task automatic runVecs(input int first, input int last);
      for (int i = first; i < last; i++) begin
         applyStimulus(vecs[i]);
         #2;
         checkOutput($sformatf("vec%0d", i));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idleVec(input logic [XLEN-1:0] epc, input logic [FW-1:0] emask, input logic [EW-1:0] eep,
                          input logic ev, input logic [1:0] est);
      addVec(2'b00, '0, '0, 1'b0, '0, 1'b0, 1'b1, ev, epc, emask, eep, est);
   endtask

   initial begin
      int split1;
      int split2;
      vec_t rv;

      // Boot and sequential fetch
      idleVec(64'h8000_0000, 4'b1111, 3'd0, 1'b0, 2'd0);
      idleVec(64'h8000_0000, 4'b1111, 3'd0, 1'b1, 2'd1);
      idleVec(64'h8000_0010, 4'b1111, 3'd0, 1'b1, 2'd1);
      idleVec(64'h8000_0020, 4'b1111, 3'd0, 1'b1, 2'd1);
      // Unaligned redirect
      addVec(2'b01, 64'h1008, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 64'h1008, 4'b1100, 3'd1, 2'd1);
      idleVec(64'h1010, 4'b1111, 3'd1, 1'b1, 2'd1);
      // Priority and backpressure
      addVec(2'b11, 64'h2000, 64'h3000, 1'b0, '0, 1'b0, 1'b0, 1'b1, 64'h2000, 4'b1111, 3'd2, 2'd1);
      for (int i = 0; i < 3; i++) begin
         addVec(2'b00, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 64'h2000, 4'b1111, 3'd2, 2'd1);
      end
      idleVec(64'h2000, 4'b1111, 3'd2, 1'b1, 2'd1);
      idleVec(64'h2010, 4'b1111, 3'd2, 1'b1, 2'd1);
      // Predictor
      addVec(2'b01, 64'h4000, '0, 1'b1, 64'h9000, 1'b0, 1'b0, 1'b1, 64'h4000, 4'b1111, 3'd3, 2'd1);
      addVec(2'b00, '0, '0, 1'b1, 64'h5006, 1'b0, 1'b1, 1'b1, 64'h4000, 4'b1111, 3'd3, 2'd1);
      addVec(2'b00, '0, '0, 1'b1, 64'h7000, 1'b0, 1'b0, 1'b1, 64'h5004, 4'b1110, 3'd3, 2'd1);
      idleVec(64'h5004, 4'b1110, 3'd3, 1'b1, 2'd1);
      // Halt held across halt_i toggling, exited only by a redirect
      addVec(2'b00, '0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 64'h5010, 4'b1111, 3'd3, 2'd1);
      for (int i = 0; i < 5; i++) begin
         addVec(2'b00, '0, '0, 1'b0, '0, 1'(i % 2), 1'b1, 1'b0, 64'h5010, 4'b1111, 3'd3, 2'd2);
      end
      addVec(2'b01, 64'h6000, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 64'h6000, 4'b1111, 3'd4, 2'd2);
      idleVec(64'h6010, 4'b1111, 3'd4, 1'b1, 2'd1);
      // Lone lower-priority source
      addVec(2'b10, 64'hDEAD0, 64'h3000, 1'b0, '0, 1'b0, 1'b1, 1'b1, 64'h3000, 4'b1111, 3'd5, 2'd1);
      // Address wrap
      addVec(2'b01, 64'hFFFF_FFFF_FFFF_FFF0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 4'b1111, 3'd6, 2'd1);
      idleVec(64'hFFFF_FFFF_FFFF_FFF0, 4'b1111, 3'd6, 1'b1, 2'd1);
      idleVec(64'h0, 4'b1111, 3'd6, 1'b1, 2'd1);
      // Epoch wrap
      addVec(2'b01, 64'h100, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 64'h100, 4'b1111, 3'd7, 2'd1);
      addVec(2'b01, 64'h200, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 64'h200, 4'b1111, 3'd0, 2'd1);
      // Halt and redirect together
      addVec(2'b01, 64'h30E, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 64'h30C, 4'b1000, 3'd1, 2'd1);
      idleVec(64'h310, 4'b1111, 3'd1, 1'b1, 2'd1);
      split1 = vecs.size();
      // After the mid-stream reset to 0x1234_5677
      idleVec(64'h1234_5674, 4'b1110, 3'd0, 1'b0, 2'd0);
      idleVec(64'h1234_5674, 4'b1110, 3'd0, 1'b1, 2'd1);
      idleVec(64'h1234_5680, 4'b1111, 3'd0, 1'b1, 2'd1);
      // Redirect beats a firing predictor
      addVec(2'b01, 64'h800, '0, 1'b1, 64'h9000, 1'b0, 1'b1, 1'b1, 64'h800, 4'b1111, 3'd1, 2'd1);
      idleVec(64'h810, 4'b1111, 3'd1, 1'b1, 2'd1);
      split2 = vecs.size();

      rst_n     = 1'b0;
      reset_vec = 64'h8000_0002;
      rv = vecs[0];
      rv.expState = 2'd0;
      applyStimulus(rv);
      #12;
      checkOutput("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      runVecs(0, split1);

      rst_n     = 1'b0;
      reset_vec = 64'h1234_5677;
      rv = vecs[split1];
      applyStimulus(rv);
      #1;
      checkOutput("asyncReset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      runVecs(split1, split2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
